// File: rtl/menu_ctrl.sv
// menu_ctrl: debounced 5-button menu FSM (hidden/browse/edit) editing five BCD values; ports clk, rst, newframe, btn_*, menu_on, edit, sel, out_*, update
module menu_ctrl #(
  parameter int DB_CYCLES      = 1000,
  parameter int REPEAT_DELAY   = 30,
  parameter int REPEAT_RATE    = 4,
  parameter int TIMEOUT_FRAMES = 600,
  parameter int MAX_MODE       = 15,
  parameter int MAX_AGC        = 3,
  parameter int MAX_LVL        = 99999,
  parameter int MAX_TINT       = 999,
  parameter int DEF_MODE       = 0,
  parameter int DEF_AGC        = 0,
  parameter int DEF_LVL1       = 0,
  parameter int DEF_LVL2       = 0,
  parameter int DEF_TINT       = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        newframe,
  input  logic        btn_menu,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_inc,
  input  logic        btn_dec,
  output logic        menu_on,
  output logic        edit,
  output logic [2:0]  sel,
  output logic [19:0] out_mode,
  output logic [19:0] out_type_agc,
  output logic [19:0] out_set_lvl1,
  output logic [19:0] out_set_lvl2,
  output logic [19:0] out_time_int,
  output logic        update
);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int RD = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RD + 1);
  localparam int TW = $clog2(TIMEOUT_FRAMES + 1);

  function automatic logic [19:0] bcd(input int v);
    logic [19:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [19:0] step(input logic [19:0] v, input logic up);
    logic [19:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 5; i++)
      if (c) begin
        if (up) begin
          c = r[4*i +: 4] == 4'd9;
          r[4*i +: 4] = c ? 4'd0 : r[4*i +: 4] + 4'd1;
        end else begin
          c = r[4*i +: 4] == 4'd0;
          r[4*i +: 4] = c ? 4'd9 : r[4*i +: 4] - 4'd1;
        end
      end
    return r;
  endfunction

  localparam logic [19:0] MX [5] = '{bcd(MAX_MODE), bcd(MAX_AGC), bcd(MAX_LVL), bcd(MAX_LVL), bcd(MAX_TINT)};
  localparam logic [19:0] DF [5] = '{bcd(DEF_MODE), bcd(DEF_AGC), bcd(DEF_LVL1), bcd(DEF_LVL2), bcd(DEF_TINT)};

  typedef enum logic [1:0] {HIDDEN, BROWSE, EDIT} state_t;

  state_t        st, st_n;
  logic [2:0]    sel_n;
  logic [19:0]   val [5];
  logic [19:0]   val_n [5];
  logic [TW-1:0] tmo, tmo_n;
  logic          upd_n;
  logic [4:0]    raw, ev, win;
  logic [19:0]   cur, mx, nv;
  logic          wrap;

  assign raw = {btn_dec, btn_inc, btn_down, btn_up, btn_menu};

  for (genvar g = 0; g < 5; g++) begin : btn
    logic [1:0]    s;
    logic          db, dbq, blk, rep;
    logic [DW-1:0] dc;
    logic [RW-1:0] rc;
    // blk holds the debouncer as if the button were down until a full
    // debounced release is seen, so a press held through reset never fires
    always_ff @(posedge clk)
      if (rst) begin
        s   <= '0;
        db  <= 1'b0;
        dbq <= 1'b0;
        blk <= 1'b1;
        dc  <= '0;
        rc  <= '0;
      end else begin
        s   <= {s[0], raw[g]};
        dbq <= db;
        if (s[1] == (db | blk)) dc <= '0;
        else if (dc == DW'(DB_CYCLES - 1)) begin
          dc <= '0;
          if (blk) blk <= 1'b0;
          else db <= s[1];
        end else dc <= dc + 1'b1;
        if (db & ~dbq) rc <= RW'(REPEAT_DELAY);
        else if (db && newframe) rc <= (rc == RW'(1)) ? RW'(REPEAT_RATE) : rc - 1'b1;
      end
    assign rep   = db & dbq & newframe & (rc == RW'(1));
    assign ev[g] = (db & ~dbq) | (rep & (g != 0));
  end

  // lowest index wins: menu > up > down > inc > dec
  assign win  = ev & (~ev + 5'd1);
  assign cur  = val[sel];
  assign mx   = MX[sel];
  assign wrap = sel < 3'd2;
  assign nv   = win[3] ? (cur == mx ? (wrap ? '0 : cur) : step(cur, 1'b1))
                       : (cur == '0 ? (wrap ? mx : '0) : step(cur, 1'b0));

  always_ff @(posedge clk)
    if (rst) begin
      st     <= HIDDEN;
      sel    <= '0;
      val    <= DF;
      tmo    <= '0;
      update <= 1'b0;
    end else begin
      st     <= st_n;
      sel    <= sel_n;
      val    <= val_n;
      tmo    <= tmo_n;
      update <= upd_n;
    end

  always_comb begin
    st_n  = st;
    sel_n = sel;
    val_n = val;
    tmo_n = tmo;
    upd_n = 1'b0;
    if (st == HIDDEN) begin
      tmo_n = '0;
      if (win[0]) st_n = BROWSE;
    end else if (|ev) begin
      tmo_n = '0;
      if (win[0]) st_n = (st == BROWSE) ? EDIT : BROWSE;
      else if (st == BROWSE && win[1]) sel_n = (sel == 3'd0) ? 3'd4 : sel - 3'd1;
      else if (st == BROWSE && win[2]) sel_n = (sel == 3'd4) ? 3'd0 : sel + 3'd1;
      else if (st == EDIT && |win[4:3]) begin
        val_n[sel] = nv;
        upd_n = nv != cur;
      end
    end else if (newframe) begin
      st_n  = (tmo == TW'(TIMEOUT_FRAMES - 1)) ? HIDDEN : st;
      tmo_n = (tmo == TW'(TIMEOUT_FRAMES - 1)) ? '0 : tmo + 1'b1;
    end
  end

  assign menu_on      = st != HIDDEN;
  assign edit         = st == EDIT;
  assign out_mode     = val[0];
  assign out_type_agc = val[1];
  assign out_set_lvl1 = val[2];
  assign out_set_lvl2 = val[3];
  assign out_time_int = val[4];
endmodule

// File: tb/tb_menu_ctrl.sv
// tb_menu_ctrl: directed self-checking bench for menu_ctrl
module tb_menu_ctrl;
  logic        clk = 1'b0, rst = 1'b1, newframe = 1'b0;
  logic [4:0]  btn = '0;
  logic        menu_on, edit, update;
  logic [2:0]  sel;
  logic [19:0] out_mode, out_type_agc, out_set_lvl1, out_set_lvl2, out_time_int;
  int total = 0, bad = 0, upd_cnt = 0;

  menu_ctrl #(
    .DB_CYCLES(4), .REPEAT_DELAY(30), .REPEAT_RATE(4), .TIMEOUT_FRAMES(50),
    .DEF_MODE(15), .DEF_AGC(0), .DEF_LVL1(99), .DEF_LVL2(99999), .DEF_TINT(1)
  ) dut (
    .clk(clk), .rst(rst), .newframe(newframe),
    .btn_menu(btn[0]), .btn_up(btn[1]), .btn_down(btn[2]), .btn_inc(btn[3]), .btn_dec(btn[4]),
    .menu_on(menu_on), .edit(edit), .sel(sel),
    .out_mode(out_mode), .out_type_agc(out_type_agc), .out_set_lvl1(out_set_lvl1),
    .out_set_lvl2(out_set_lvl2), .out_time_int(out_time_int), .update(update)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (update === 1'b1) upd_cnt++;

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    cyc(10);
    btn[b] = 1'b0;
    cyc(10);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      newframe = 1'b1;
      cyc(1);
      newframe = 1'b0;
      cyc(1);
    end
  endtask

  initial begin
    cyc(3);
    chk("rst_menu_on", menu_on, 0);
    chk("rst_edit", edit, 0);
    chk("rst_sel", sel, 0);
    chk("rst_update", update, 0);
    chk("rst_mode", out_mode, 20'h00015);
    chk("rst_agc", out_type_agc, 20'h00000);
    chk("rst_lvl1", out_set_lvl1, 20'h00099);
    chk("rst_lvl2", out_set_lvl2, 20'h99999);
    chk("rst_tint", out_time_int, 20'h00001);
    rst = 1'b0;
    cyc(10);
    btn[0] = 1'b1;
    cyc(6);
    chk("lat_before", menu_on, 0);
    cyc(1);
    chk("lat_after", menu_on, 1);
    chk("browse_edit", edit, 0);
    btn[0] = 1'b0;
    cyc(10);
    press(1);
    chk("up_wrap_sel", sel, 4);
    press(2);
    chk("down_wrap_sel", sel, 0);
    press(2);
    press(2);
    chk("sel2", sel, 2);
    press(3);
    chk("browse_inc_ign", out_set_lvl1, 20'h00099);
    chk("browse_inc_upd", upd_cnt, 0);
    press(0);
    chk("edit_on", edit, 1);
    press(3);
    chk("lvl1_carry", out_set_lvl1, 20'h00100);
    chk("lvl1_upd", upd_cnt, 1);
    press(4);
    chk("lvl1_borrow", out_set_lvl1, 20'h00099);
    chk("lvl1_dec_upd", upd_cnt, 2);
    press(0);
    press(2);
    press(0);
    chk("sel3", sel, 3);
    press(3);
    chk("lvl2_sat", out_set_lvl2, 20'h99999);
    chk("lvl2_sat_noupd", upd_cnt, 2);
    press(1);
    chk("edit_up_ign", sel, 3);
    press(0);
    press(1);
    press(1);
    press(1);
    press(0);
    chk("sel0", sel, 0);
    press(3);
    chk("mode_wrap_up", out_mode, 20'h00000);
    press(4);
    chk("mode_wrap_dn", out_mode, 20'h00015);
    chk("mode_upd", upd_cnt, 4);
    press(0);
    press(2);
    press(2);
    press(0);
    btn[3] = 1'b1;
    cyc(10);
    frames(40);
    btn[3] = 1'b0;
    cyc(10);
    chk("repeat_lvl1", out_set_lvl1, 20'h00103);
    chk("repeat_upd", upd_cnt, 8);
    btn[3] = 1'b1;
    cyc(3);
    btn[3] = 1'b0;
    cyc(10);
    chk("glitch_lvl1", out_set_lvl1, 20'h00103);
    chk("glitch_upd", upd_cnt, 8);
    btn[0] = 1'b1;
    btn[3] = 1'b1;
    cyc(10);
    btn = '0;
    cyc(10);
    chk("prio_edit", edit, 0);
    chk("prio_menu_on", menu_on, 1);
    chk("prio_lvl1", out_set_lvl1, 20'h00103);
    press(1);
    press(0);
    press(4);
    chk("agc_wrap_dn", out_type_agc, 20'h00003);
    chk("agc_upd", upd_cnt, 9);
    press(0);
    press(2);
    press(2);
    press(2);
    press(0);
    chk("sel4", sel, 4);
    press(4);
    chk("tint_dec", out_time_int, 20'h00000);
    press(4);
    chk("tint_sat0", out_time_int, 20'h00000);
    chk("tint_upd", upd_cnt, 10);
    press(0);
    frames(49);
    chk("tmo_before", menu_on, 1);
    frames(1);
    chk("tmo_after", menu_on, 0);
    chk("tmo_lvl1_kept", out_set_lvl1, 20'h00103);
    press(0);
    chk("reshow_on", menu_on, 1);
    chk("reshow_sel", sel, 4);
    press(0);
    chk("edit_again", edit, 1);
    btn[0] = 1'b1;
    cyc(10);
    chk("held_to_browse", edit, 0);
    rst = 1'b1;
    cyc(2);
    chk("rst2_menu_on", menu_on, 0);
    chk("rst2_sel", sel, 0);
    chk("rst2_lvl1", out_set_lvl1, 20'h00099);
    chk("rst2_agc", out_type_agc, 20'h00000);
    chk("rst2_tint", out_time_int, 20'h00001);
    rst = 1'b0;
    cyc(20);
    chk("held_thru_rst", menu_on, 0);
    chk("rst_noupd", upd_cnt, 10);
    btn[0] = 1'b0;
    cyc(10);
    press(0);
    chk("repress_on", menu_on, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
